// File: rtl/conv_out_streamer.sv
// rtl/conv_out_streamer.sv - snapshots the conv_layer output array and streams it out in raster order
module conv_out_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int OUTROW     = 24,
    parameter int OUTCOL     = 24
) (
    input  logic                  clk,            // system clock
    input  logic                  rst,            // asynchronous active-low reset
    input  logic [DATA_WIDTH-1:0] conv_out [0:OUTROW-1][0:OUTCOL-1], // conv_layer result array
    input  logic                  layer_done_in,  // level done flag from conv_layer
    output logic [DATA_WIDTH-1:0] m_data,         // streamed pixel
    output logic                  m_valid,        // m_data valid
    input  logic                  m_ready,        // downstream accepts beat
    output logic                  m_eol,          // beat is last column of a row
    output logic                  m_last,         // beat is final pixel of frame
    output logic                  busy,           // frame in progress
    output logic                  stream_done,    // pulse after final beat accepted
    output logic                  overrun         // sticky: done edge arrived while busy
);

    localparam int RW = (OUTROW > 1) ? $clog2(OUTROW) : 1;
    localparam int CW = (OUTCOL > 1) ? $clog2(OUTCOL) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(OUTROW - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(OUTCOL - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                state;
    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
    logic                  done_q;
    logic                  start;
    logic                  at_eol;
    logic                  at_last;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] frame_mem [0:OUTROW-1][0:OUTCOL-1];

    // done_q resets to 0, so a level already high at reset release reads as an edge
    assign start   = layer_done_in & ~done_q;
    assign at_eol  = (col == COL_LAST);
    assign at_last = at_eol & (row == ROW_LAST);
    assign xfer    = m_valid & m_ready;

    // m_valid is high exactly while streaming, so it gates the beat fields to 0 elsewhere
    assign m_data = m_valid ? frame_mem[row][col] : '0;
    assign m_eol  = m_valid & at_eol;
    assign m_last = m_valid & at_last;

    // Whole-array snapshot; only taken from IDLE so a busy frame is never overwritten
    always_ff @(posedge clk) begin
        if ((state == IDLE) && start) begin
            frame_mem <= conv_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            done_q      <= 1'b0;
            m_valid     <= 1'b0;
            busy        <= 1'b0;
            stream_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done_q      <= layer_done_in;
            stream_done <= 1'b0;
            if (start && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= STREAM;
                        row     <= '0;
                        col     <= '0;
                        m_valid <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (at_last) begin
                            state       <= DONE;
                            m_valid     <= 1'b0;
                            stream_done <= 1'b1;
                            row         <= '0;
                            col         <= '0;
                        end else if (at_eol) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_out_streamer.sv
// tb/tb_conv_out_streamer.sv - self-checking bench for conv_out_streamer
module tb_conv_out_streamer;

    localparam int DW   = 8;
    localparam int R    = 24;
    localparam int C    = 24;
    localparam int NPIX = R * C;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] conv_out [0:R-1][0:C-1];
    logic          layer_done_in;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_valid, m_eol, m_last, busy, stream_done, overrun;

    int n_cmp = 0;
    int n_err = 0;

    // reference frame: the array as it stood when the start edge was given
    logic [DW-1:0] snap [0:R-1][0:C-1];

    int nb, first_k, last_k, done_k, done_cnt, busy_after;
    int stall_err, gap_err, idle_err, beat_err, first_bad, n_eol, n_last;

    always #5 clk = ~clk;

    conv_out_streamer #(.DATA_WIDTH(DW), .OUTROW(R), .OUTCOL(C)) dut (
        .clk          (clk),
        .rst          (rst),
        .conv_out     (conv_out),
        .layer_done_in(layer_done_in),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_eol        (m_eol),
        .m_last       (m_last),
        .busy         (busy),
        .stream_done  (stream_done),
        .overrun      (overrun)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang want completion");
        $fatal(1, "watchdog");
    end

    task automatic fill_ramp();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                conv_out[r][c] = 8'((r * C + c) & 255);
    endtask

    task automatic fill_random();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                conv_out[r][c] = 8'($urandom_range(0, 255));
    endtask

    task automatic fill_const(input logic [DW-1:0] v);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                conv_out[r][c] = v;
    endtask

    // Gives the rising edge at a negedge; collection cycle k counts negedges from here
    task automatic raise_start();
        @(negedge clk);
        snap          = conv_out;
        layer_done_in = 1'b1;
    endtask

    task automatic drop_done();
        @(negedge clk);
        layer_done_in = 1'b0;
        @(negedge clk);
    endtask

    // Observes one frame; period 0 = random ready, n = ready every n-th cycle.
    // Raster-order expectation: beat i is snap[i/C][i%C], eol when i%C==C-1, last at i==NPIX-1.
    task automatic collect(input int period, input int max_beats, input int toggle_at, input int budget);
        logic [DW-1:0] pd;
        logic          pe, pl, stalled;
        nb = 0; first_k = -1; last_k = -1; done_k = -1; done_cnt = 0; busy_after = -1;
        stall_err = 0; gap_err = 0; idle_err = 0; beat_err = 0; first_bad = -1; n_eol = 0; n_last = 0;
        stalled = 1'b0; pd = '0; pe = 1'b0; pl = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (stalled && (m_valid !== 1'b1 || m_data !== pd || m_eol !== pe || m_last !== pl))
                stall_err++;
            if (m_valid !== 1'b1 && (m_data !== '0 || m_eol !== 1'b0 || m_last !== 1'b0))
                idle_err++;
            if (stream_done === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k > done_k) begin
                busy_after = int'(busy);
                break;
            end
            if (nb > 0 && nb < NPIX && m_valid !== 1'b1) gap_err++;
            if (toggle_at > 0 && nb == toggle_at)     layer_done_in = 1'b0;
            if (toggle_at > 0 && nb == toggle_at + 1) layer_done_in = 1'b1;
            if (period == 0) m_ready = 1'($urandom_range(0, 1));
            else             m_ready = ((k % period) == 0);
            stalled = (m_valid === 1'b1) && !m_ready;
            pd = m_data; pe = m_eol; pl = m_last;
            if (m_valid === 1'b1 && m_ready) begin
                if (nb >= NPIX || m_data !== snap[nb / C][nb % C] ||
                    m_eol !== ((nb % C) == C - 1) || m_last !== (nb == NPIX - 1)) begin
                    beat_err++;
                    if (first_bad < 0) first_bad = nb;
                end
                n_eol  += int'(m_eol);
                n_last += int'(m_last);
                if (first_k < 0) first_k = k;
                last_k = k;
                nb++;
                if (max_beats > 0 && nb == max_beats) break;
            end
        end
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            fill_random();
            layer_done_in = 1'($urandom_range(0, 1));
            m_ready       = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if ({m_valid, m_data, m_eol, m_last, busy, stream_done, overrun} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got %b want all zero",
                         {m_valid, m_data, m_eol, m_last, busy, stream_done, overrun});
            end
        end
        @(negedge clk);
        layer_done_in = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (m_valid !== 1'b0) begin
                n_err++;
                $display("FAIL idle_after_reset: cycle %0d m_valid=%b want 0", i, m_valid);
            end
        end
    endtask

    task automatic test_ramp();
        fill_ramp();
        m_ready = 1'b1;
        raise_start();
        collect(1, 0, 0, 1000);
        n_cmp++; if (nb !== NPIX)       begin n_err++; $display("FAIL ramp_beats: got %0d want %0d", nb, NPIX); end
        n_cmp++; if (beat_err !== 0)    begin n_err++; $display("FAIL ramp_data: %0d bad beats, first %0d, want 0", beat_err, first_bad); end
        n_cmp++; if (first_k !== 1)     begin n_err++; $display("FAIL ramp_first_beat: cycle %0d want 1", first_k); end
        n_cmp++; if (last_k !== NPIX)   begin n_err++; $display("FAIL ramp_last_beat: cycle %0d want %0d", last_k, NPIX); end
        n_cmp++; if (n_eol !== R)       begin n_err++; $display("FAIL ramp_eol_count: got %0d want %0d", n_eol, R); end
        n_cmp++; if (n_last !== 1)      begin n_err++; $display("FAIL ramp_last_count: got %0d want 1", n_last); end
        n_cmp++; if (done_k !== NPIX+1) begin n_err++; $display("FAIL ramp_done_cycle: got %0d want %0d", done_k, NPIX + 1); end
        n_cmp++; if (done_cnt !== 1)    begin n_err++; $display("FAIL ramp_done_pulses: got %0d want 1", done_cnt); end
        n_cmp++; if (busy_after !== 0)  begin n_err++; $display("FAIL ramp_busy_after: got %0d want 0", busy_after); end
        n_cmp++; if (idle_err !== 0)    begin n_err++; $display("FAIL ramp_idle_zero: got %0d want 0", idle_err); end
        drop_done();
    endtask

    task automatic test_backpressure();
        for (int pass = 0; pass < 2; pass++) begin
            fill_random();
            raise_start();
            collect(pass == 0 ? 3 : 0, 0, 0, 5000);
            n_cmp++; if (nb !== NPIX)         begin n_err++; $display("FAIL bp%0d_beats: got %0d want %0d", pass, nb, NPIX); end
            n_cmp++; if (beat_err !== 0)      begin n_err++; $display("FAIL bp%0d_data: %0d bad beats, first %0d, want 0", pass, beat_err, first_bad); end
            n_cmp++; if (stall_err !== 0)     begin n_err++; $display("FAIL bp%0d_stall_stable: got %0d want 0", pass, stall_err); end
            n_cmp++; if (gap_err !== 0)       begin n_err++; $display("FAIL bp%0d_valid_gap: got %0d want 0", pass, gap_err); end
            n_cmp++; if (done_k !== last_k+1) begin n_err++; $display("FAIL bp%0d_done_cycle: got %0d want %0d", pass, done_k, last_k + 1); end
            n_cmp++; if (done_cnt !== 1)      begin n_err++; $display("FAIL bp%0d_done_pulses: got %0d want 1", pass, done_cnt); end
            drop_done();
        end
    endtask

    task automatic test_snapshot();
        fill_ramp();
        raise_start();
        fork
            collect(1, 0, 0, 1000);
            begin
                repeat (3) @(negedge clk);
                fill_const(8'hAA);
            end
        join
        n_cmp++; if (nb !== NPIX)    begin n_err++; $display("FAIL snap_beats: got %0d want %0d", nb, NPIX); end
        n_cmp++; if (beat_err !== 0) begin n_err++; $display("FAIL snap_ramp_kept: %0d bad beats, first %0d, want 0", beat_err, first_bad); end
        drop_done();
        raise_start();
        collect(1, 0, 0, 1000);
        n_cmp++; if (nb !== NPIX)    begin n_err++; $display("FAIL snap2_beats: got %0d want %0d", nb, NPIX); end
        n_cmp++; if (beat_err !== 0) begin n_err++; $display("FAIL snap2_aa: %0d bad beats, first %0d, want 0", beat_err, first_bad); end
        drop_done();
    endtask

    task automatic test_overrun();
        int extra;
        fill_random();
        raise_start();
        collect(1, 0, 0, 1000);
        n_cmp++; if (beat_err !== 0 || nb !== NPIX) begin n_err++; $display("FAIL held_frame: %0d bad, %0d beats, want 0 bad %0d beats", beat_err, nb, NPIX); end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            extra += int'(m_valid);
        end
        n_cmp++; if (extra !== 0)     begin n_err++; $display("FAIL held_no_retrigger: %0d valid cycles want 0", extra); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL held_overrun: got %b want 0", overrun); end
        drop_done();
        fill_random();
        raise_start();
        fork
            collect(1, 0, 100, 1000);
            begin
                repeat (3) @(negedge clk);
                fill_random();
            end
        join
        n_cmp++; if (nb !== NPIX)      begin n_err++; $display("FAIL ovr_beats: got %0d want %0d", nb, NPIX); end
        n_cmp++; if (beat_err !== 0)   begin n_err++; $display("FAIL ovr_data: %0d bad beats, first %0d, want 0", beat_err, first_bad); end
        n_cmp++; if (done_cnt !== 1)   begin n_err++; $display("FAIL ovr_done_pulses: got %0d want 1", done_cnt); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", overrun); end
        drop_done();
        repeat (5) @(negedge clk);
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_midframe_reset();
        int pulses;
        fill_random();
        raise_start();
        collect(1, 100, 0, 1000);
        n_cmp++; if (nb !== 100) begin n_err++; $display("FAIL mid_pre_beats: got %0d want 100", nb); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if ({m_valid, busy} !== 2'b00) begin n_err++; $display("FAIL mid_async_drop: valid/busy=%b want 00", {m_valid, busy}); end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pulses += int'(stream_done);
        end
        layer_done_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pulses += int'(stream_done) + int'(m_valid);
        end
        n_cmp++; if (pulses !== 0)      begin n_err++; $display("FAIL mid_no_done: got %0d activity cycles want 0", pulses); end
        n_cmp++; if (overrun !== 1'b0)  begin n_err++; $display("FAIL mid_overrun_clear: got %b want 0", overrun); end
        fill_random();
        raise_start();
        collect(1, 0, 0, 1000);
        n_cmp++; if (nb !== NPIX)    begin n_err++; $display("FAIL mid_restart_beats: got %0d want %0d", nb, NPIX); end
        n_cmp++; if (beat_err !== 0) begin n_err++; $display("FAIL mid_restart_data: %0d bad beats, first %0d, want 0", beat_err, first_bad); end
        drop_done();
    endtask

    initial begin
        rst = 1'b0;
        layer_done_in = 1'b0;
        m_ready = 1'b0;
        fill_const(8'h00);
        snap = conv_out;
        test_reset();
        test_ramp();
        test_backpressure();
        test_snapshot();
        test_overrun();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_out_streamer.md
Name: conv_out_streamer

Overview:
- Reads the 2-D convolution output array from conv_layer once its layer_done_out asserts.
- Snapshots the array into an internal frame buffer, so conv_layer is free to start the next layer.
- Streams the buffered pixels out in raster order (row 0 col 0 first) over a valid/ready handshake with row-end and frame-end markers.
- Sits between conv_layer and the downstream pooling/serial-output logic.

Parameters:
- DATA_WIDTH, 8, bit width of each output pixel.
- OUTROW, 24, rows of the conv output (IMGROW-KERNEL_SIZE+1).
- OUTCOL, 24, columns of the conv output (IMGCOL-KERNEL_SIZE+1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- conv_out  input  [DATA_WIDTH-1:0] x [0:OUTROW-1][0:OUTCOL-1]  conv_layer result array.
- layer_done_in  input  1  level done flag from conv_layer.
- m_data  output  DATA_WIDTH  streamed pixel.
- m_valid  output  1  m_data valid.
- m_ready  input  1  downstream accepts beat.
- m_eol  output  1  beat is last column of a row.
- m_last  output  1  beat is final pixel of frame.
- busy  output  1  frame in progress (STREAM or DONE state).
- stream_done  output  1  one-cycle pulse after final beat accepted.
- overrun  output  1  sticky: a done edge arrived while busy.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is asynchronous and active-low.
- Reset (rst=0), applied immediately and asynchronously:
  - m_valid=0, m_data=0, m_eol=0, m_last=0, busy=0, stream_done=0, overrun=0.
  - State IDLE; row/col counters 0; done_q=0; buffer contents don't-care.
- Edge detect:
  - done_q registers layer_done_in every cycle.
  - start = layer_done_in & ~done_q.
  - A level already high when reset releases counts as one edge.
  - A level held high afterwards never retriggers.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - On start in cycle N: whole conv_out array copied into the buffer at the clk edge ending cycle N; counters cleared; state becomes STREAM in cycle N+1.
  - Otherwise IDLE is held.
- STREAM:
  - m_valid=1, busy=1.
  - m_data = buf[row][col], driven combinationally from the buffer and counters.
  - m_eol = (col==OUTCOL-1).
  - m_last = m_eol & (row==OUTROW-1).
  - Transfer occurs when m_valid & m_ready.
  - On transfer: col increments; at OUTCOL-1, col wraps to 0 and row increments.
  - Without transfer, m_data/m_eol/m_last hold stable. m_valid never drops mid-frame.
  - Transfer with m_last=1 → DONE.
- DONE (exactly one cycle): m_valid=0, stream_done=1, busy=1; then IDLE.
- Outside STREAM: m_data, m_eol, m_last are 0.
- start while in STREAM or DONE: ignored (frame not restarted, buffer not rewritten); overrun set to 1, cleared only by reset.
- Changes on conv_out after capture do not affect the streamed frame.
- Throughput: one beat per cycle with m_ready held high. With m_ready=1 constantly:
  - Beats occur in cycles N+1 .. N+OUTROW*OUTCOL.
  - stream_done pulses in cycle N+OUTROW*OUTCOL+1.
  - IDLE resumes the following cycle.
- Reset mid-frame: the frame is aborted with no stream_done pulse. The next start after reset release streams from [0][0].
- Counter widths: $clog2(OUTROW) and $clog2(OUTCOL), minimum 1 bit.
- Pixel data passes through unmodified; no arithmetic.

Test Plan:
1. Reset check: hold rst=0 with random inputs → all outputs 0. Release with layer_done_in=0 → m_valid stays 0 for 10 cycles.
2. Ramp frame, m_ready=1:
   - Stimulus: conv_out[r][c]=(r*24+c)&8'hFF, layer_done_in rises at cycle N.
   - 576 beats, values 0..255,0..255,0..63, in cycles N+1..N+576.
   - m_eol on beats 24, 48, … 576; m_last only on beat 576.
   - stream_done single pulse at N+577; busy low at N+578.
3. Backpressure: m_ready high one cycle in three → identical 576-value sequence, no loss or duplication. m_data/m_valid/m_eol stable on every stalled cycle; stream_done 1 cycle after final accept.
4. Snapshot: after start, overwrite conv_out with 8'hAA everywhere → stream still emits the ramp. A new rising edge after stream_done emits all 8'hAA.
5. Overrun: layer_done_in held high for the whole frame → exactly one frame, overrun=0. Drop layer_done_in and raise it again at beat 100 → frame continues unchanged, overrun=1 and sticky.
6. Mid-frame reset: assert rst=0 at beat 100 → m_valid/busy drop to 0 immediately, no stream_done pulse. After release, a new rising edge restarts at conv_out[0][0].
